// File: rtl/decode_queue_if.sv
// Handshake bundle between fetch, decode_queue and execute.
// The master modport is the pipeline side; the slave modport is the queue itself.
interface decode_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_inst;
    logic [31:0]   in_pc;
    logic          out_valid;
    logic          out_ready;
    logic [31:0]   out_inst;
    logic [31:0]   out_pc;
    logic [2:0]    out_class;
    logic          out_regwrite;
    logic [4:0]    out_wreg;
    logic          out_memen;
    logic          out_ex_ri;
    logic          out_ex_sys;
    logic          out_ex_bp;
    logic          out_eret;
    logic [CW-1:0] count;

    modport master (
        output flush, in_valid, in_inst, in_pc, out_ready,
        input  in_ready, out_valid, out_inst, out_pc, out_class, out_regwrite,
               out_wreg, out_memen, out_ex_ri, out_ex_sys, out_ex_bp, out_eret, count
    );

    modport slave (
        input  flush, in_valid, in_inst, in_pc, out_ready,
        output in_ready, out_valid, out_inst, out_pc, out_class, out_regwrite,
               out_wreg, out_memen, out_ex_ri, out_ex_sys, out_ex_bp, out_eret, count
    );
endinterface

// File: rtl/decode_queue.sv
// Decoding instruction FIFO: classifies each fetched word on enqueue and
// presents the stored control bundle in order to the execute stage.
module decode_queue #(
    parameter int DEPTH   = 4,
    parameter bit EXT_MUL = 1'b0
) (
    input  logic          clk,
    input  logic          resetn,
    decode_queue_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        CLS_ALU    = 3'd0,
        CLS_LOAD   = 3'd1,
        CLS_STORE  = 3'd2,
        CLS_BRANCH = 3'd3,
        CLS_JUMP   = 3'd4,
        CLS_HILO   = 3'd5,
        CLS_CP0    = 3'd6,
        CLS_TRAP   = 3'd7
    } cls_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        cls_e        cls;
        logic        regwrite;
        logic [4:0]  wreg;
        logic        memen;
        logic        ex_ri;
        logic        ex_sys;
        logic        ex_bp;
        logic        eret;
    } entry_t;

    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] sa;

    assign op    = bus.in_inst[31:26];
    assign rs    = bus.in_inst[25:21];
    assign rt    = bus.in_inst[20:16];
    assign rd    = bus.in_inst[15:11];
    assign sa    = bus.in_inst[10:6];
    assign funct = bus.in_inst[5:0];

    cls_e       d_cls;
    logic       d_write;
    logic [4:0] d_wreg;
    logic       d_ri;
    logic       d_sys;
    logic       d_bp;
    logic       d_eret;

    always_comb begin
        d_cls   = CLS_ALU;
        d_write = 1'b0;
        d_wreg  = 5'd0;
        d_ri    = 1'b0;
        d_sys   = 1'b0;
        d_bp    = 1'b0;
        d_eret  = 1'b0;
        case (op)
            6'h00: begin
                case (funct)
                    6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25,
                    6'h26, 6'h27, 6'h2a, 6'h2b: begin
                        d_write = 1'b1;
                        d_wreg  = rd;
                    end
                    6'h08: d_cls = CLS_JUMP;
                    6'h09: begin
                        d_cls   = CLS_JUMP;
                        d_write = 1'b1;
                        d_wreg  = rd;
                    end
                    6'h0c: begin
                        d_cls = CLS_TRAP;
                        d_sys = 1'b1;
                    end
                    6'h0d: begin
                        d_cls = CLS_TRAP;
                        d_bp  = 1'b1;
                    end
                    6'h10, 6'h12: begin
                        d_cls   = CLS_HILO;
                        d_write = 1'b1;
                        d_wreg  = rd;
                    end
                    6'h11, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b: d_cls = CLS_HILO;
                    default: d_ri = 1'b1;
                endcase
            end
            6'h01: begin
                case (rt)
                    5'h00, 5'h01: d_cls = CLS_BRANCH;
                    5'h10, 5'h11: begin
                        d_cls   = CLS_BRANCH;
                        d_write = 1'b1;
                        d_wreg  = 5'd31;
                    end
                    default: d_ri = 1'b1;
                endcase
            end
            6'h02: d_cls = CLS_JUMP;
            6'h03: begin
                d_cls   = CLS_JUMP;
                d_write = 1'b1;
                d_wreg  = 5'd31;
            end
            6'h04, 6'h05, 6'h06, 6'h07: d_cls = CLS_BRANCH;
            6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: begin
                d_write = 1'b1;
                d_wreg  = rt;
            end
            // ERET is matched on the whole word before the MF/MT rs decode
            6'h10: begin
                if (bus.in_inst == 32'h4200_0018) begin
                    d_cls  = CLS_CP0;
                    d_eret = 1'b1;
                end else if (rs == 5'h00) begin
                    d_cls   = CLS_CP0;
                    d_write = 1'b1;
                    d_wreg  = rt;
                end else if (rs == 5'h04) begin
                    d_cls = CLS_CP0;
                end else begin
                    d_ri = 1'b1;
                end
            end
            6'h1c: begin
                if (EXT_MUL && funct == 6'h02 && sa == 5'd0) begin
                    d_write = 1'b1;
                    d_wreg  = rd;
                end else begin
                    d_ri = 1'b1;
                end
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                d_cls   = CLS_LOAD;
                d_write = 1'b1;
                d_wreg  = rt;
            end
            6'h28, 6'h29, 6'h2b: d_cls = CLS_STORE;
            default: d_ri = 1'b1;
        endcase
        if (d_ri) begin
            d_cls = CLS_TRAP;
        end
    end

    entry_t d_entry;

    always_comb begin
        d_entry          = '0;
        d_entry.inst     = bus.in_inst;
        d_entry.pc       = bus.in_pc;
        d_entry.cls      = d_cls;
        d_entry.wreg     = d_wreg;
        d_entry.regwrite = d_write && (d_wreg != 5'd0) && !d_ri && !d_sys && !d_bp;
        d_entry.memen    = (d_cls == CLS_LOAD) || (d_cls == CLS_STORE);
        d_entry.ex_ri    = d_ri;
        d_entry.ex_sys   = d_sys;
        d_entry.ex_bp    = d_bp;
        d_entry.eret     = d_eret;
    end

    entry_t        mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] count_q;
    logic          enq;
    logic          deq;

    // in_ready already excludes flush, so only the dequeue needs gating
    assign enq = bus.in_valid && bus.in_ready;
    assign deq = (count_q != '0) && bus.out_ready && !bus.flush;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (bus.flush) begin
            rd_ptr  <= '0;
            wr_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (enq) begin
                mem[wr_ptr] <= d_entry;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (deq) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count_q <= count_q + CW'(enq) - CW'(deq);
        end
    end

    entry_t head;
    assign head = mem[rd_ptr];

    assign bus.in_ready     = (count_q < CW'(DEPTH)) && !bus.flush;
    assign bus.out_valid    = (count_q != '0);
    assign bus.count        = count_q;
    assign bus.out_inst     = head.inst;
    assign bus.out_pc       = head.pc;
    assign bus.out_class    = head.cls;
    assign bus.out_regwrite = head.regwrite;
    assign bus.out_wreg     = head.wreg;
    assign bus.out_memen    = head.memen;
    assign bus.out_ex_ri    = head.ex_ri;
    assign bus.out_ex_sys   = head.ex_sys;
    assign bus.out_ex_bp    = head.ex_bp;
    assign bus.out_eret     = head.eret;
endmodule

// File: doc/decode_queue.md
# decode_queue

Buffered instruction decoder placed between instruction fetch and the execute stage. It accepts fetched instructions (inst, pc) over a valid/ready handshake and classifies each one into a compact control bundle at enqueue time. Decoded entries are held in a DEPTH-entry FIFO and presented in order over a second valid/ready handshake. A synchronous flush discards all buffered work on branch redirects and exceptions. Parameters set queue depth and enable the optional SPECIAL2 MUL extension.

## Interface
- DEPTH, 4, FIFO entries; power of two, >= 2
- EXT_MUL, 0, 1 = accept SPECIAL2 MUL (op 011100, funct 000010) as a valid instruction
- clk  in  1  clock, all state on rising edge
- resetn  in  1  asynchronous, active-low reset
- flush  in  1  synchronous clear of all entries
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  queue can accept
- in_inst  in  32  instruction word
- in_pc  in  32  instruction address
- out_valid  out  1  head entry valid
- out_ready  in  1  execute consumes the head entry
- out_inst  out  32  head instruction word
- out_pc  out  32  head address
- out_class  out  3  0 ALU, 1 LOAD, 2 STORE, 3 BRANCH, 4 JUMP, 5 HILO, 6 CP0, 7 TRAP
- out_regwrite  out  1  writes a GPR
- out_wreg  out  5  destination GPR
- out_memen  out  1  data SRAM access
- out_ex_ri  out  1  reserved instruction
- out_ex_sys  out  1  SYSCALL
- out_ex_bp  out  1  BREAK
- out_eret  out  1  ERET
- count  out  $clog2(DEPTH)+1  occupancy

## Operation
- Decode is applied to in_inst in the cycle it is accepted. The decoded bundle is stored with inst and pc. No decode happens at the output side.
- Classes:
  - LOAD: LB, LBU, LH, LHU, LW.
  - STORE: SB, SH, SW.
  - BRANCH: BEQ, BNE, BGTZ, BLEZ, BLTZ, BGEZ, BLTZAL, BGEZAL.
  - JUMP: J, JAL, JR, JALR.
  - HILO: MULT, MULTU, DIV, DIVU, MFHI, MFLO, MTHI, MTLO.
  - CP0: MFC0, MTC0, ERET.
  - TRAP: SYSCALL, BREAK, and every ex_ri instruction.
  - ALU: all remaining valid instructions (R-type arithmetic, logic and shifts; ADDI, ADDIU, SLTI, SLTIU, ANDI, ORI, XORI, LUI; MUL when EXT_MUL=1).
- out_wreg:
  - rd for R-type writers (including JALR) and for MUL.
  - rt for immediate ALU ops, loads and MFC0.
  - 31 for JAL, BLTZAL, BGEZAL.
  - 0 otherwise.
- out_regwrite is 1 for exactly the writers listed under out_wreg, and is forced to 0 when the computed wreg is 0.
- out_memen = 1 for LOAD and STORE classes only.
- ERET is the exact word 0x42000018: class CP0, eret=1.
- op 010000 with an rs other than MF/MT and not matching ERET sets ex_ri.
- MUL with EXT_MUL=0 sets ex_ri. MUL with EXT_MUL=1 also requires shamt=0, otherwise it sets ex_ri.
- Any ex_ri entry has class TRAP, regwrite=0 and memen=0. ex_sys and ex_bp likewise force regwrite=0 and memen=0.
- Enqueue when in_valid && in_ready. Dequeue when out_valid && out_ready. Both may happen in one cycle, and count is then unchanged.
- in_ready = (count < DEPTH) && !flush. It has no combinational path from out_ready.
- out_valid = (count != 0). Payload outputs always show the entry at the read pointer.
- flush has priority: read pointer, write pointer and count go to 0 on the next edge. Any enqueue or dequeue offered in the flush cycle is discarded.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (resetn low, asynchronous): pointers and count go to 0 and all storage is cleared.
  - out_valid=0, in_ready=1 (given flush=0), count=0, and every payload output is 0.
  - Reset asserted mid-transfer drops all entries immediately.
- Latency: an instruction accepted at edge N is visible with out_valid=1 after edge N. There is no same-cycle bypass when empty.
- Full (count=DEPTH): in_ready=0. A dequeue in that cycle frees a slot that becomes visible the next cycle.
- Empty: out_ready is ignored. A concurrent enqueue makes count 1.
- Throughput: one enqueue plus one dequeue per cycle sustained at any occupancy from 1 to DEPTH-1.
- Flush: count=0 and out_valid=0 from the edge after flush is sampled. in_ready reads 0 while flush is high.

## Test plan
- Reset, then enqueue 0x8C820004 (LW $2,4($4)) at pc 0xBFC00000 → next cycle out_valid=1, class=1, wreg=2, regwrite=1, memen=1, count=1.
- Fill DEPTH=4 with out_ready=0 → in_ready=0 at count=4. Raise out_ready with in_valid held → one dequeue and one enqueue per cycle, order preserved, pointers wrap.
- Enqueue 0x0C000010 (JAL) → class=4, wreg=31, regwrite=1. Enqueue 0x00000021 (ADDU $0) → wreg=0, regwrite=0.
- Enqueue 0x70641002 (MUL) with EXT_MUL=0 → class=7, ex_ri=1, regwrite=0. With EXT_MUL=1 → class=0, wreg=2, regwrite=1, ex_ri=0.
- Enqueue 0x42000018 → class=6, eret=1. Then 0x0000000C → ex_sys=1. Then 0x0000000D → ex_bp=1. Then 0x42800000 → ex_ri=1.
- With 3 entries queued, assert flush while in_valid=1 and out_ready=1 → next cycle count=0 and out_valid=0, nothing enqueued. Drop resetn mid-stream → outputs return to reset values immediately.
